// File: rtl/bus_ram_if.sv
// Bus connection for bus_ram: request/ready handshake, byte-masked write and read-valid response.
interface bus_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30
) ();
  logic                  bus_req;
  logic                  bus_ready;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_mask_w;
  logic [DATA_W-1:0]     bus_data_w;
  logic [DATA_W-1:0]     bus_data_r;
  logic                  bus_valid_r;
  logic                  bus_err;

  modport master (
    output bus_req, bus_addr, bus_mask_w, bus_data_w,
    input  bus_ready, bus_data_r, bus_valid_r, bus_err
  );

  modport slave (
    input  bus_req, bus_addr, bus_mask_w, bus_data_w,
    output bus_ready, bus_data_r, bus_valid_r, bus_err
  );
endinterface

// File: rtl/bus_ram.sv
// Single-port bus memory with byte-lane writes, pipelined reads, post-reset zero fill
// and a sticky out-of-range flag.
module bus_ram #(
  parameter int    DATA_W  = 32,
  parameter int    ADDR_W  = 30,
  parameter int    DEPTH   = 8192,
  parameter int    LATENCY = 1,
  parameter bit    CLEAR   = 1'b1,
  parameter string TYPE    = "block"
) (
  input logic      clock,
  input logic      reset,
  bus_ram_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {SClear, SIdle} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   cnt, cnt_next;
  logic               clr_we;

  (* ram_style = TYPE *) logic [DATA_W-1:0] mem [DEPTH];

  logic               accept;
  logic               is_read;
  logic               in_range;
  logic [IDX_W-1:0]   idx;

  logic [LATENCY-1:0] pv;
  logic [DATA_W-1:0]  pd [LATENCY];
  logic               err;

  assign bus.bus_ready = (state == SIdle);
  assign accept   = bus.bus_req && bus.bus_ready && !reset;
  assign is_read  = (bus.bus_mask_w == '0);
  assign in_range = {1'b0, bus.bus_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = bus.bus_addr[IDX_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR ? SClear : SIdle;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    case (state)
      SClear: begin
        clr_we   = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1))
          state_next = SIdle;
      end
      SIdle:   ;
      default: state_next = SIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (accept && !is_read && in_range) begin
      for (int unsigned i = 0; i < LANES; i++)
        if (bus.bus_mask_w[i])
          mem[idx][8*i +: 8] <= bus.bus_data_w[8*i +: 8];
    end
  end

  // Data stages only advance alongside their valid bit, so the last stage
  // naturally holds the previous result while no read is emerging.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv  <= '0;
      err <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++)
        pd[i] <= '0;
    end else begin
      pv[0] <= accept && is_read;
      if (accept && is_read)
        pd[0] <= in_range ? mem[idx] : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1])
          pd[i] <= pd[i-1];
      end
      if (accept && !in_range)
        err <= 1'b1;
    end
  end

  assign bus.bus_valid_r = pv[LATENCY-1];
  assign bus.bus_data_r  = pd[LATENCY-1];
  assign bus.bus_err     = err;
endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram: one 16-word instance at latency 1 and one at latency 3.
module tb_bus_ram;
  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bus_ram_if #(.DATA_W(32), .ADDR_W(30)) ia ();
  bus_ram_if #(.DATA_W(32), .ADDR_W(30)) ib ();

  bus_ram #(.DATA_W(32), .ADDR_W(30), .DEPTH(16), .LATENCY(1), .CLEAR(1'b1), .TYPE("block"))
    dut_a (.clock(clock), .reset(rst_a), .bus(ia));

  bus_ram #(.DATA_W(32), .ADDR_W(30), .DEPTH(16), .LATENCY(3), .CLEAR(1'b1), .TYPE("block"))
    dut_b (.clock(clock), .reset(rst_b), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [29:0] addr, input logic [3:0] mask, input logic [31:0] data);
    @(negedge clock);
    ia.bus_req = 1'b1; ia.bus_addr = addr; ia.bus_mask_w = mask; ia.bus_data_w = data;
    @(negedge clock);
    ia.bus_req = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [29:0] addr, input logic [31:0] exp);
    @(negedge clock);
    ia.bus_req = 1'b1; ia.bus_addr = addr; ia.bus_mask_w = 4'b0000;
    @(negedge clock);
    ia.bus_req = 1'b0;
    chk({tag, ".valid"}, 32'(ia.bus_valid_r), 32'd1);
    chk(tag, ia.bus_data_r, exp);
  endtask

  task automatic wr_b(input logic [29:0] addr, input logic [31:0] data);
    @(negedge clock);
    ib.bus_req = 1'b1; ib.bus_addr = addr; ib.bus_mask_w = 4'b1111; ib.bus_data_w = data;
    @(negedge clock);
    ib.bus_req = 1'b0;
  endtask

  // Counts rising edges until ready is seen, then drops any held request.
  task automatic wait_ready_a(output int n);
    n = 0;
    while (!ia.bus_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    ia.bus_req = 1'b0;
  endtask

  initial begin
    int   n;
    logic saw;

    ia.bus_req = 1'b0; ia.bus_addr = '0; ia.bus_mask_w = '0; ia.bus_data_w = '0;
    ib.bus_req = 1'b0; ib.bus_addr = '0; ib.bus_mask_w = '0; ib.bus_data_w = '0;

    @(negedge clock);
    chk("a.rst_ready", 32'(ia.bus_ready), 32'd0);
    chk("a.rst_valid", 32'(ia.bus_valid_r), 32'd0);
    chk("a.rst_data",  ia.bus_data_r, 32'h0);
    chk("a.rst_err",   32'(ia.bus_err), 32'd0);
    chk("b.rst_ready", 32'(ib.bus_ready), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_ready_a(n);
    chk("a.clear_len0", n, 32'd16);

    for (int i = 0; i < 16; i++) wr_a(30'(i), 4'b1111, 32'hDEADBEEF);
    rd_a("a.fill9", 30'd9, 32'hDEADBEEF);

    // Reset with a write held on the bus throughout the clear
    @(negedge clock);
    rst_a = 1'b1;
    ia.bus_req = 1'b1; ia.bus_addr = 30'd3; ia.bus_mask_w = 4'b1111; ia.bus_data_w = 32'h12345678;
    @(negedge clock);
    rst_a = 1'b0;
    wait_ready_a(n);
    chk("a.clear_len1", n, 32'd16);
    for (int i = 0; i < 16; i++) rd_a($sformatf("a.clr%0d", i), 30'(i), 32'h0);

    wr_a(30'd5, 4'b1111, 32'h11223344);
    wr_a(30'd5, 4'b0101, 32'hAABBCCDD);
    rd_a("a.lane0101", 30'd5, 32'h11BB33DD);
    wr_a(30'd5, 4'b0100, 32'h00EE0000);
    rd_a("a.lane0100", 30'd5, 32'h11EE33DD);
    wr_a(30'd5, 4'b1010, 32'h99008800);
    rd_a("a.lane1010", 30'd5, 32'h99EE88DD);
    @(negedge clock);
    chk("a.hold_valid", 32'(ia.bus_valid_r), 32'd0);
    chk("a.hold_data",  ia.bus_data_r, 32'h99EE88DD);

    @(negedge clock);
    ia.bus_req = 1'b1; ia.bus_addr = 30'd6; ia.bus_mask_w = 4'b1111; ia.bus_data_w = 32'hCAFEF00D;
    @(negedge clock);
    ia.bus_mask_w = 4'b0000;
    @(negedge clock);
    ia.bus_req = 1'b0;
    chk("a.wr_rd.valid", 32'(ia.bus_valid_r), 32'd1);
    chk("a.wr_rd", ia.bus_data_r, 32'hCAFEF00D);

    wr_a(30'd4, 4'b1111, 32'h44444444);
    chk("a.err_before", 32'(ia.bus_err), 32'd0);
    wr_a(30'd20, 4'b1111, 32'h00000005);
    chk("a.err_set", 32'(ia.bus_err), 32'd1);
    rd_a("a.oor20", 30'd20, 32'h0);
    chk("a.err_sticky", 32'(ia.bus_err), 32'd1);
    rd_a("a.mem4", 30'd4, 32'h44444444);

    @(negedge clock);
    rst_a = 1'b1;
    #1;
    chk("a.rst2_err",   32'(ia.bus_err), 32'd0);
    chk("a.rst2_data",  ia.bus_data_r, 32'h0);
    chk("a.rst2_ready", 32'(ia.bus_ready), 32'd0);
    @(negedge clock);
    rst_a = 1'b0;
    repeat (7) @(negedge clock);
    chk("a.midclear_ready", 32'(ia.bus_ready), 32'd0);
    rst_a = 1'b1;
    @(negedge clock);
    rst_a = 1'b0;
    wait_ready_a(n);
    chk("a.clear_len2", n, 32'd16);
    rd_a("a.after_restart5", 30'd5, 32'h0);

    for (int i = 0; i < 8; i++) wr_b(30'(i), 32'(i * 3));
    @(negedge clock);
    ib.bus_req = 1'b1; ib.bus_addr = 30'd0; ib.bus_mask_w = 4'b0000;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      chk($sformatf("b.valid%0d", j), 32'(ib.bus_valid_r), (j >= 2 && j < 10) ? 32'd1 : 32'd0);
      if (j >= 2 && j < 10)
        chk($sformatf("b.data%0d", j), ib.bus_data_r, 32'((j - 2) * 3));
      if (j + 1 < 8) ib.bus_addr = 30'(j + 1);
      else           ib.bus_req = 1'b0;
    end

    @(negedge clock);
    ib.bus_req = 1'b1; ib.bus_addr = 30'd1; ib.bus_mask_w = 4'b0000;
    @(negedge clock);
    ib.bus_addr = 30'd2;
    @(negedge clock);
    ib.bus_req = 1'b0;
    rst_b = 1'b1;
    #1;
    saw = ib.bus_valid_r;
    repeat (3) begin
      @(negedge clock);
      saw = saw | ib.bus_valid_r;
    end
    rst_b = 1'b0;
    n = 0;
    while (!ib.bus_ready && n < 100) begin
      @(negedge clock);
      n++;
      saw = saw | ib.bus_valid_r;
    end
    repeat (4) begin
      @(negedge clock);
      saw = saw | ib.bus_valid_r;
    end
    chk("b.inflight_pulse", 32'(saw), 32'd0);
    chk("b.clear_len", n, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bus_ram.md
# bus_ram

Parametrised single-port bus memory, the successor to the fixed 32-bit word RAM used in the CPU test harness. It generalises data width, depth and read latency. It adds a request/ready handshake, read-valid signalling and a post-reset clear sequencer that zero-fills the array. It also adds out-of-range detection. It sits directly on the CPU data/instruction bus, both in simulation benches and in FPGA builds.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, ≥8
- ADDR_W, 30, word-address width
- DEPTH, 8192, number of words; 2 ≤ DEPTH ≤ 2^ADDR_W
- LATENCY, 1, read latency in cycles; legal range 1..4
- CLEAR, 1, 1 = zero-fill the array after reset; 0 = no fill (contents undefined, or preloaded by `$readmemh`)
- TYPE, "block", ram_style synthesis attribute applied to the array
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- bus_req  in  1  request strobe
- bus_ready  out  1  block can accept a request this cycle
- bus_addr  in  ADDR_W  word address
- bus_mask_w  in  DATA_W/8  byte-lane write enables; all-zero = read
- bus_data_w  in  DATA_W  write data; lane i = bits [8i+7:8i]
- bus_data_r  out  DATA_W  read data
- bus_valid_r  out  1  bus_data_r carries a read result this cycle
- bus_err  out  1  sticky out-of-range flag

## Operation
- Accept: a request is accepted on a rising edge where bus_req=1 and bus_ready=1. Inputs are ignored on every other edge.
- Write (mask ≠ 0): each lane i with mask[i]=1 writes mem[addr] bits [8i+7:8i]. Other lanes are unchanged. No response, and bus_valid_r is unaffected.
- Read (mask = 0): returns mem[addr] after LATENCY cycles, with bus_valid_r=1 for exactly one cycle per accepted read. The read pipeline is fully pipelined at one read per cycle, and results return in order.
- Out of range (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads still produce a valid response, with data 0.
  - bus_err is set and stays 1 until reset.
- bus_data_r holds its last value while bus_valid_r=0.
- Clear FSM, states SClear and SIdle:
  - Reset forces the state to SClear if CLEAR=1, otherwise SIdle. The clear counter is reset to 0.
  - In SClear, each edge writes 0 to mem[cnt] and increments cnt. When cnt = DEPTH-1 is written, the FSM moves to SIdle.
  - bus_ready = (state == SIdle).
  - SIdle is terminal until the next reset.
- Reset while in SClear restarts the clear from address 0.
- Reset while reads are in flight discards them. No bus_valid_r pulse is produced for those reads.
- The array itself is not affected by reset, apart from the clear sequence.

## Timing
- Reset values: bus_ready=0 if CLEAR=1, else 1; bus_valid_r=0; bus_data_r=0; bus_err=0; pipeline valid bits all 0.
- Clear duration: bus_ready rises after exactly DEPTH rising edges following reset deassertion.
- Read issued at edge k: bus_valid_r=1 and bus_data_r valid between edge k+LATENCY-1 and edge k+LATENCY. For LATENCY=1, data is available the cycle after the accepting edge, matching the legacy RAM.
- Write at edge k followed by a read of the same address at edge k+1 returns the written data. There is no forwarding path; the array write commits at edge k.
- Back-to-back write then read at the same edge cannot occur, because the block is single-port with one request per edge.
- bus_err is set on the edge that accepts the offending request.

## Test plan
- Clear: DEPTH=16, CLEAR=1. Preload 0xDEADBEEF everywhere, then pulse reset. Required: bus_ready=0 for 16 edges, then 1. Reads of all 16 addresses return 0x00000000.
- Byte lanes: write 0x11223344 with mask 1111, then 0xAABBCCDD with mask 0101, then read. Required: 0x11BB33DD, and each lane is independent, including lane 2 bits [23:16].
- Latency and streaming: LATENCY=3. Issue 8 back-to-back reads of addresses 0..7, each holding value addr*3. Required: bus_valid_r high for 8 consecutive cycles starting 2 cycles after the first accept, with data 0,3,...,21 in order.
- Out of range: DEPTH=16. Write 0x5 to addr 20, then read addr 20 and addr 4. Required: the addr 20 read returns 0 with valid=1, bus_err=1 from the first accept onward, and mem[4] is unchanged.
- Reset mid-operation: assert reset during clear (cnt=7) and also with 2 reads in flight. Required: no bus_valid_r pulse, and the clear restarts from 0 and lasts a full DEPTH edges.
- Handshake gating: hold bus_req=1 with a write during SClear. Required: the write is ignored, and the location reads 0 after the clear completes.
